pe_col_arbiter: RTL and testbench

//  Round-robin arbiter sharing one result bus among the NUM_COL PE columns of the global PE set.

---
 rtl/pe_col_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pe_col_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_arbiter.sv
// pe_col_arbiter
//   Round-robin arbiter that shares one result bus among NUM_COL PE columns.
//   A grant is a burst of max(kernel_size,1) beats from a single column. Each
//   beat carries the granted column index as its tag. There is one IDLE cycle
//   between bursts, and the search for the next grant starts after the column
//   that was served last.
//   Optional feature: define ARB_WDT_EN to enable the stall watchdog. It aborts
//   a burst after WDT_CYCLES cycles in which the granted column shows no valid
//   beat, and pulses err_timeout. Without it, err_timeout is tied 0.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               abort current burst, restart arbitration at column 0
//   kernel_size         burst length in beats (0 treated as 1), sampled at grant
//   req                 per-column burst request (level)
//   col_valid/col_data  per-column beat; column i at [i*DATA_WIDTH +: DATA_WIDTH]
//   col_ready           beat accepted from column i
//   out_valid/out_data  muxed result beat
//   out_tag/out_last    granted column (zero-extended), final beat of burst
//   out_ready           downstream accepts the beat
//   busy, flush_busy    state != IDLE, state == FLUSH
//   err_timeout         one-cycle watchdog pulse
module pe_col_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 8,
  parameter int WDT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [7:0]                      kernel_size,
  input  logic [NUM_COL-1:0]              req,
  input  logic [NUM_COL-1:0]              col_valid,
  input  logic [NUM_COL*DATA_WIDTH-1:0]   col_data,
  output logic [NUM_COL-1:0]              col_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_COL):0]        out_tag,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            flush_busy,
  output logic                            err_timeout
);

  localparam int IW = $clog2(NUM_COL);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, rr_nx;
  logic [IW-1:0]   grant, grant_nx;
  logic [IW-1:0]   grant_inc;
  logic [IW-1:0]   pick;
  logic            found;
  logic [7:0]      cnt, cnt_nx;
  logic [7:0]      len, len_nx;

  logic            in_burst;
  logic            cur_valid;
  logic            beat;
  logic            last_cnt;
  logic            wdt_hit;

  logic [DATA_WIDTH-1:0] col_word [NUM_COL];

  for (genvar g = 0; g < NUM_COL; g++) begin : g_unpack
    assign col_word[g] = col_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Cyclic priority search: first requesting column at or after rr_ptr.
  always_comb begin
    logic [IW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_COL; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NUM_COL);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant_inc = (grant == IW'(NUM_COL - 1)) ? '0 : grant + 1'b1;

  assign in_burst  = (state == BURST);
  assign cur_valid = col_valid[grant];
  assign last_cnt  = (cnt == len - 8'd1);

  // flush suppresses the handshake in the same cycle, so no beat can slip
  // through while the burst is being aborted.
  assign out_valid = in_burst & cur_valid & ~flush;
  assign beat      = out_valid & out_ready;
  assign out_last  = out_valid & last_cnt;
  assign out_data  = in_burst ? col_word[grant] : '0;
  assign out_tag   = in_burst ? {1'b0, grant} : '0;
  assign busy      = (state != IDLE);
  assign flush_busy = (state == FLUSH);

  always_comb begin
    col_ready = '0;
    if (in_burst && !flush && out_ready) col_ready[grant] = 1'b1;
  end

`ifdef ARB_WDT_EN
  localparam int SW = $clog2(WDT_CYCLES + 1);
  logic [SW-1:0] stall_cnt;

  // Fires on the WDT_CYCLES-th consecutive stalled cycle of the burst.
  assign wdt_hit     = in_burst & ~flush & ~cur_valid & (stall_cnt == SW'(WDT_CYCLES - 1));
  assign err_timeout = wdt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!in_burst || flush || beat) begin
      stall_cnt <= '0;
    end else if (!cur_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign wdt_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    grant_nx = grant;
    cnt_nx   = cnt;
    len_nx   = len;
    if (flush) begin
      state_nx = FLUSH;
      rr_nx    = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_nx = pick;
            len_nx   = (kernel_size == 8'd0) ? 8'd1 : kernel_size;
            cnt_nx   = '0;
            state_nx = BURST;
          end
        end
        BURST: begin
          if (wdt_hit) begin
            rr_nx    = grant_inc;
            state_nx = IDLE;
          end else if (beat) begin
            cnt_nx = cnt + 8'd1;
            if (last_cnt) begin
              rr_nx    = grant_inc;
              state_nx = IDLE;
            end
          end
        end
        FLUSH:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      cnt    <= '0;
      len    <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
      grant  <= grant_nx;
      cnt    <= cnt_nx;
      len    <= len_nx;
    end
  end

endmodule

// File: tb/tb_pe_col_arbiter.sv
module tb_pe_col_arbiter;
  localparam int DW  = 16;
  localparam int NC  = 8;
  localparam int TW  = 4;
  localparam int WDT = 8;

  logic              clk = 1'b0;
  logic              rst, flush, out_ready;
  logic [7:0]        kernel_size;
  logic [NC-1:0]     req, col_valid, col_ready;
  logic [NC*DW-1:0]  col_data;
  logic              out_valid, out_last, busy, flush_busy, err_timeout;
  logic [DW-1:0]     out_data;
  logic [TW-1:0]     out_tag;

  always #5 clk = ~clk;

  pe_col_arbiter #(.DATA_WIDTH(DW), .NUM_COL(NC), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .kernel_size(kernel_size),
    .req(req), .col_valid(col_valid), .col_data(col_data), .col_ready(col_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .flush_busy(flush_busy), .err_timeout(err_timeout)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] rq;
    logic [7:0] ks;
    logic       v;
    logic [3:0] tag;
    logic       l;
    logic       b;
  } vec_t;

  vec_t tbl [17];

  // reference model state
  int m_owner, m_left, m_next, m_stall;
  bit m_fl;

  int beats, k, hit_at;
  logic [7:0] exp_ready;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // T1: reset with all requests asserted
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; kernel_size = 8'd0;
    req = 8'hFF; col_valid = '0; col_data = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    check("reset_outputs", {out_valid, out_data, out_tag, out_last, col_ready, busy, flush_busy, err_timeout}, 64'd0);
    rst = 1'b0; req = '0;

    // T2/T3: table of always-valid/always-ready cycles
    col_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < NC; i++) col_data[i*DW +: DW] = 16'hA000 + 16'(i);
    tbl[0]  = '{8'h05, 8'd3, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h05, 8'd3, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[2]  = '{8'h05, 8'd3, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[3]  = '{8'h05, 8'd3, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[4]  = '{8'h05, 8'd3, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{8'h05, 8'd3, 1'b1, 4'd2, 1'b0, 1'b1};
    tbl[6]  = '{8'h05, 8'd3, 1'b1, 4'd2, 1'b0, 1'b1};
    tbl[7]  = '{8'h05, 8'd3, 1'b1, 4'd2, 1'b1, 1'b1};
    tbl[8]  = '{8'h05, 8'd3, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{8'h05, 8'd3, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[10] = '{8'h05, 8'd3, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[11] = '{8'h05, 8'd3, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[12] = '{8'h80, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[13] = '{8'h80, 8'd0, 1'b1, 4'd7, 1'b1, 1'b1};
    tbl[14] = '{8'h81, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[15] = '{8'h81, 8'd0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[16] = '{8'h00, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      req = tbl[i].rq; kernel_size = tbl[i].ks;
      #1;
      check($sformatf("tbl%0d_ctl", i), {out_valid, out_tag, out_last, busy},
            {tbl[i].v, tbl[i].tag, tbl[i].l, tbl[i].b});
      exp_ready = '0;
      if (tbl[i].v) begin
        exp_ready[tbl[i].tag[2:0]] = 1'b1;
        check($sformatf("tbl%0d_data", i), out_data, 16'hA000 + 16'(tbl[i].tag));
      end
      check($sformatf("tbl%0d_col_ready", i), col_ready, exp_ready);
      tick();
    end

    // T4: backpressure on column 1 (rr_ptr is 1 here)
    kernel_size = 8'd4; req = 8'h02; out_ready = 1'b1;
    col_data[1*DW +: DW] = 16'h0100;
    #1;
    check("bp_idle", busy, 1'b0);
    tick();
    req = '0; beats = 0; k = 0;
    while (beats < 4 && k < 16) begin
      out_ready = (k % 2 == 0);
      #1;
      check($sformatf("bp%0d_valid", k), out_valid, 1'b1);
      check($sformatf("bp%0d_data", k), out_data, 16'h0100 + 16'(beats));
      check($sformatf("bp%0d_col_ready", k), col_ready, out_ready ? 8'h02 : 8'h00);
      check($sformatf("bp%0d_last", k), out_last, beats == 3);
      if (out_valid && out_ready) beats++;
      tick();
      col_data[1*DW +: DW] = 16'h0100 + 16'(beats);
      k++;
    end
    check("bp_beats", beats, 4);
    #1;
    check("bp_done_idle", busy, 1'b0);
    tick();

    // T5: flush on beat 2 of 5 (column 5 granted, rr_ptr is 2 here)
    for (int i = 0; i < NC; i++) col_data[i*DW +: DW] = 16'hA000 + 16'(i);
    kernel_size = 8'd5; req = 8'h20; out_ready = 1'b1;
    #1; check("fl_idle", busy, 1'b0);
    tick();
    req = '0;
    #1; check("fl_beat1", {out_valid, out_tag}, {1'b1, 4'd5});
    tick();
    flush = 1'b1;
    #1;
    check("fl_col_ready", col_ready, 8'h00);
    check("fl_no_beat", out_valid & out_ready, 1'b0);
    tick();
    flush = 1'b0; req = 8'h21;
    #1; check("fl_state", {flush_busy, busy, out_valid, col_ready}, {1'b1, 1'b1, 1'b0, 8'h00});
    tick();
    #1; check("fl_after_idle", {flush_busy, busy}, 2'b00);
    tick();
    #1; check("fl_regrant_col0", {out_valid, out_tag}, {1'b1, 4'd0});
    rst = 1'b1; tick(); rst = 1'b0; req = '0;

`ifdef ARB_WDT_EN
    // T6: column 3 stalls until the watchdog fires
    kernel_size = 8'd2; req = 8'h08; col_valid = 8'hF7;
    tick();
    req = 8'h14; hit_at = 0; k = 1;
    while (hit_at == 0 && k <= 20) begin
      #1;
      if (err_timeout) hit_at = k;
      tick();
      k++;
    end
    check("wdt_cycle", hit_at, 8);
    #1; check("wdt_idle_no_err", {busy, err_timeout}, 2'b00);
    tick();
    #1; check("wdt_next_col4", {out_valid, out_tag}, {1'b1, 4'd4});
    req = '0; col_valid = 8'hFF;
`endif

    // Randomized run against a transaction-level model
    m_owner = -1; m_left = 0; m_next = 0; m_stall = 0; m_fl = 0;
    for (int i = 0; i < 500; i++) begin
      logic [7:0] e_ready;
      logic       e_valid, e_last, e_err;
      logic [DW-1:0] e_data;
      logic [TW-1:0] e_tag;
      rst   = (i == 0) || ($urandom_range(0, 79) == 0);
      flush = ($urandom_range(0, 24) == 0);
      req   = 8'($urandom & $urandom);
      kernel_size = 8'($urandom_range(0, 5));
      col_valid = 8'(~($urandom & $urandom & $urandom));
      if ($urandom_range(0, 9) == 0) col_valid = '0;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) col_data[c*DW +: DW] = 16'($urandom);
      #1;
      e_ready = '0; e_valid = 0; e_last = 0; e_err = 0; e_data = '0; e_tag = '0;
      if (m_owner >= 0) begin
        e_data = col_data[m_owner*DW +: DW];
        e_tag  = TW'(m_owner);
        if (!flush) begin
          e_valid = col_valid[m_owner];
          if (out_ready) e_ready[m_owner] = 1'b1;
`ifdef ARB_WDT_EN
          e_err = !col_valid[m_owner] && (m_stall == WDT - 1);
`endif
        end
        e_last = e_valid && (m_left == 1);
      end
      check($sformatf("rnd%0d", i),
            {out_valid, out_data, out_tag, out_last, col_ready, busy, flush_busy, err_timeout},
            {e_valid, e_data, e_tag, e_last, e_ready, (m_owner >= 0) || m_fl, m_fl, e_err});
      // model advance for this clock edge
      if (rst) begin
        m_owner = -1; m_next = 0; m_fl = 0;
      end else if (flush) begin
        m_owner = -1; m_next = 0; m_fl = 1;
      end else if (m_fl) begin
        m_fl = 0;
      end else if (m_owner < 0) begin
        for (int j = 0; j < NC; j++) begin
          if (m_owner < 0 && req[(m_next + j) % NC]) m_owner = (m_next + j) % NC;
        end
        if (m_owner >= 0) begin
          m_left  = (kernel_size == 0) ? 1 : int'(kernel_size);
          m_stall = 0;
        end
      end else if (e_valid && out_ready) begin
        m_stall = 0;
        m_left--;
        if (m_left == 0) begin
          m_next = (m_owner + 1) % NC; m_owner = -1;
        end
      end else if (!col_valid[m_owner]) begin
`ifdef ARB_WDT_EN
        m_stall++;
        if (m_stall == WDT) begin
          m_next = (m_owner + 1) % NC; m_owner = -1;
        end
`endif
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
